mmio_timer: RTL and testbench

- Memory-mapped machine timer that acts as a responder on the CPU data port (data_addr / data_wdata / data_wenable / data_rdata).
- It is also the source of the CPU's active-low irq_n line.
- It holds a prescaled 64-bit mtime counter and a 64-bit mtimecmp compare register, and asserts a pending interrupt when mtime >= mtimecmp.
- It sits behind the system address decoder, which drives sel for its 32-byte window.

---
 rtl/mmio_timer_pkg.sv | 37 +++
 rtl/mmio_timer_if.sv | 19 +
 rtl/mmio_timer_prescaler.sv | 30 +++
 rtl/mmio_timer.sv | 155 +++++++++++++++
 tb/tb_mmio_timer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// mmio_timer shared definitions: register offsets, CTRL/STATUS bits, lane merge.
// CTRL write mask depends on MMIO_TIMER_PERIODIC_EN.
package mmio_timer_pkg;

   localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;
   localparam logic [4:0] MTIMER_OFF_STATUS      = 5'h14;
   localparam logic [4:0] MTIMER_OFF_PRESCALE    = 5'h18;

   localparam int MTIMER_CTRL_EN        = 0;
   localparam int MTIMER_CTRL_IRQ_EN    = 1;
   localparam int MTIMER_CTRL_PERIODIC  = 2;
   localparam int MTIMER_STATUS_PENDING = 0;

`ifdef MMIO_TIMER_PERIODIC_EN
   localparam logic [2:0] MTIMER_CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] MTIMER_CTRL_MASK = 3'b011;
`endif

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-port slice seen by the timer window.
// master = CPU side, slave = timer side.
interface mmio_timer_if;
   logic        sel;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wenable;
   logic [31:0] rdata;

   modport master (
      output sel, addr, wdata, wenable,
      input  rdata
   );

   modport slave (
      input  sel, addr, wdata, wenable,
      output rdata
   );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// mmio_timer_prescaler: divides clk by (reload + 1) while en is high.
// clear restarts the count; tick is high on the wrapping cycle.
module mmio_timer_prescaler #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] reload,
   input  logic         clear,
   output logic         tick
);

   logic [W-1:0] pcnt;
   logic         wrap;

   assign wrap = (pcnt == reload);
   assign tick = en && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (clear) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= wrap ? '0 : pcnt + W'(1);
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 64-bit machine timer with prescaler and irq_n.
// Optional periodic reload is built when MMIO_TIMER_PERIODIC_EN is defined.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter int          PRESCALE_W = 16,
   parameter logic [63:0] RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   mmio_timer_if.slave bus,
   output logic        irq_n
);

   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic [2:0]            ctrl;
   logic                  pending;
   logic [PRESCALE_W-1:0] prescale;

   logic [7:0]  hit;
   logic        wr;
   logic        wr_mtl, wr_mth, wr_cml, wr_cmh;
   logic        wr_ctl, wr_sts, wr_pre;
   logic        tick, match, wrap_ld, w1c;
   logic [31:0] mtl_nx, mth_nx, cml_nx, cmh_nx, pre_nx;
   logic        unused_bits;

   assign hit = 8'd1 << bus.addr[4:2];
   assign wr  = bus.sel && (bus.wenable != 4'b0000);

   assign wr_mtl = wr && hit[MTIMER_OFF_MTIME_LO[4:2]];
   assign wr_mth = wr && hit[MTIMER_OFF_MTIME_HI[4:2]];
   assign wr_cml = wr && hit[MTIMER_OFF_MTIMECMP_LO[4:2]];
   assign wr_cmh = wr && hit[MTIMER_OFF_MTIMECMP_HI[4:2]];
   assign wr_ctl = wr && hit[MTIMER_OFF_CTRL[4:2]];
   assign wr_sts = wr && hit[MTIMER_OFF_STATUS[4:2]];
   assign wr_pre = wr && hit[MTIMER_OFF_PRESCALE[4:2]];

   assign mtl_nx = lane_merge(mtime[31:0], bus.wdata, bus.wenable);
   assign mth_nx = lane_merge(mtime[63:32], bus.wdata, bus.wenable);
   assign cml_nx = lane_merge(mtimecmp[31:0], bus.wdata, bus.wenable);
   assign cmh_nx = lane_merge(mtimecmp[63:32], bus.wdata, bus.wenable);
   assign pre_nx = lane_merge(32'(prescale), bus.wdata, bus.wenable);

   assign unused_bits = ^{bus.addr[1:0], pre_nx, hit[7]};

   assign match = (mtime >= mtimecmp);
   assign w1c   = wr_sts
               && bus.wenable[MTIMER_STATUS_PENDING]
               && bus.wdata[MTIMER_STATUS_PENDING];

   mmio_timer_prescaler #(
      .W (PRESCALE_W)
   ) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ctrl[MTIMER_CTRL_EN]),
      .reload (prescale),
      .clear  (wr_pre),
      .tick   (tick)
   );

`ifdef MMIO_TIMER_PERIODIC_EN
   // 65-bit so an all-ones mtime does not alias to 0
   logic [64:0] mtime_inc;
   assign mtime_inc = {1'b0, mtime} + 65'd1;
   assign wrap_ld   = tick
                   && ctrl[MTIMER_CTRL_PERIODIC]
                   && (mtime_inc >= {1'b0, mtimecmp})
                   && !(wr_mtl || wr_mth);
`else
   assign wrap_ld = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime <= '0;
      end else if (wr_mtl) begin
         mtime[31:0] <= mtl_nx;
      end else if (wr_mth) begin
         mtime[63:32] <= mth_nx;
      end else if (wrap_ld) begin
         mtime <= '0;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtimecmp <= RESET_CMP;
      end else if (wr_cml) begin
         mtimecmp[31:0] <= cml_nx;
      end else if (wr_cmh) begin
         mtimecmp[63:32] <= cmh_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl     <= '0;
         prescale <= '0;
      end else begin
         if (wr_ctl && bus.wenable[0])
            ctrl <= bus.wdata[2:0] & MTIMER_CTRL_MASK;
         if (wr_pre)
            prescale <= pre_nx[PRESCALE_W-1:0];
      end
   end

   // clear beats a same-cycle set; level match re-arms next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (w1c) begin
         pending <= 1'b0;
      end else if (match || wrap_ld) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_n <= 1'b1;
      end else begin
         irq_n <= ~(pending && ctrl[MTIMER_CTRL_IRQ_EN]);
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.sel) begin
         unique case (1'b1)
            hit[MTIMER_OFF_MTIME_LO[4:2]]:
               bus.rdata = mtime[31:0];
            hit[MTIMER_OFF_MTIME_HI[4:2]]:
               bus.rdata = mtime[63:32];
            hit[MTIMER_OFF_MTIMECMP_LO[4:2]]:
               bus.rdata = mtimecmp[31:0];
            hit[MTIMER_OFF_MTIMECMP_HI[4:2]]:
               bus.rdata = mtimecmp[63:32];
            hit[MTIMER_OFF_CTRL[4:2]]:
               bus.rdata = {29'd0, ctrl};
            hit[MTIMER_OFF_STATUS[4:2]]:
               bus.rdata = {31'd0, pending};
            hit[MTIMER_OFF_PRESCALE[4:2]]:
               bus.rdata = 32'(prescale);
            default:
               bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized and directed checks of mmio_timer against
// a cycle-level behavioural model of the register map.
module tb_mmio_timer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic irq_n;
   int   vectors = 0;
   int   errs = 0;

   mmio_timer_if bus();

   mmio_timer #(
      .PRESCALE_W (16),
      .RESET_CMP  (64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .irq_n (irq_n)
   );

   always #5 clk = ~clk;

`ifdef MMIO_TIMER_PERIODIC_EN
   localparam bit HAS_PER = 1'b1;
`else
   localparam bit HAS_PER = 1'b0;
`endif

   logic [63:0] m_time, m_cmp;
   logic [2:0]  m_ctrl;
   logic        m_pend, m_irq_n;
   logic [15:0] m_pre, m_pcnt;

   function automatic logic [31:0] put(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_time = 64'd0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ctrl = 3'd0;
      m_pend = 1'b0;
      m_irq_n = 1'b1;
      m_pre = 16'd0;
      m_pcnt = 16'd0;
   endtask

   task automatic model_step(
      input logic        s,
      input logic [4:0]  a,
      input logic [31:0] wd,
      input logic [3:0]  be
   );
      logic        w, en, tick, match, rel, clr;
      logic [2:0]  r;
      logic [63:0] nt;
      logic [64:0] inc;
      logic [31:0] tmp;
      w = s && (be != 4'd0);
      r = a[4:2];
      en = m_ctrl[0];
      tick = en && (m_pcnt == m_pre);
      match = (m_time >= m_cmp);
      rel = 1'b0;
      nt = m_time;
      inc = {1'b0, m_time} + 65'd1;
      if (w && r == 3'd0) nt[31:0] = put(m_time[31:0], wd, be);
      else if (w && r == 3'd1) nt[63:32] = put(m_time[63:32], wd, be);
      else if (tick) begin
         if (HAS_PER && m_ctrl[2] && inc >= {1'b0, m_cmp}) begin
            nt = 64'd0;
            rel = 1'b1;
         end else begin
            nt = m_time + 64'd1;
         end
      end
      clr = w && r == 3'd5 && be[0] && wd[0];
      m_irq_n = !(m_pend && m_ctrl[1]);
      m_pend = clr ? 1'b0 : (m_pend || match || rel);
      if (w && r == 3'd6) m_pcnt = 16'd0;
      else if (en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
      if (w && r == 3'd2) m_cmp[31:0] = put(m_cmp[31:0], wd, be);
      if (w && r == 3'd3) m_cmp[63:32] = put(m_cmp[63:32], wd, be);
      if (w && r == 3'd4 && be[0])
         m_ctrl = wd[2:0] & (HAS_PER ? 3'b111 : 3'b011);
      if (w && r == 3'd6) begin
         tmp = put({16'd0, m_pre}, wd, be);
         m_pre = tmp[15:0];
      end
      m_time = nt;
   endtask

   function automatic logic [31:0] model_read(
      input logic       s,
      input logic [4:0] a
   );
      if (!s) return 32'd0;
      case (a[4:2])
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {29'd0, m_ctrl};
         3'd5: return {31'd0, m_pend};
         3'd6: return {16'd0, m_pre};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(
      input string       nm,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step(bus.sel, bus.addr, bus.wdata, bus.wenable);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("rdata", 64'(bus.rdata), 64'(model_read(bus.sel, bus.addr)));
         chk("irq_n", 64'(irq_n), 64'(m_irq_n));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(
      input logic [4:0]  a,
      input logic [31:0] d,
      input logic [3:0]  be
   );
      bus.sel = 1'b1;
      bus.addr = a;
      bus.wdata = d;
      bus.wenable = be;
      @(posedge clk);
      #1;
      bus.sel = 1'b0;
      bus.wenable = 4'd0;
   endtask

   task automatic rdv(input logic [4:0] a, output logic [31:0] v);
      bus.sel = 1'b1;
      bus.addr = a;
      bus.wenable = 4'd0;
      #2;
      v = bus.rdata;
      @(posedge clk);
      #1;
      bus.sel = 1'b0;
   endtask

   task automatic rd(
      input string       nm,
      input logic [4:0]  a,
      input logic [31:0] exp
   );
      logic [31:0] v;
      rdv(a, v);
      chk(nm, 64'(v), 64'(exp));
   endtask

   logic [31:0] rexp [8];
   logic [31:0] v;

   initial begin
      bus.sel = 1'b0;
      bus.addr = 5'd0;
      bus.wdata = 32'd0;
      bus.wenable = 4'd0;
      rexp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 32'd0, 32'd0, 32'd0};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      chk("irq_rst", 64'(irq_n), 1);
      #2 chk("rdata_nosel", 64'(bus.rdata), 0);
      for (int i = 0; i < 8; i++)
         rd($sformatf("rst_%02h", i * 4), 5'(i * 4), rexp[i]);

      // prescale 3: one tick per 4 enabled cycles
      wr(5'h18, 32'd3, 4'hF);
      wr(5'h10, 32'd1, 4'hF);
      idle(40);
      rdv(5'h00, v);
      chk("mtime_40", 64'(v >= 9 && v <= 11), 1);
      chk("mtime_40x", 64'(v), 10);
      wr(5'h10, 32'd0, 4'hF);
      bus.sel = 1'b1;
      bus.addr = 5'h00;
      idle(20);
      bus.sel = 1'b0;
      rd("mtime_hold", 5'h00, 32'd10);

      wr(5'h0C, 32'd0, 4'hF);
      wr(5'h08, 32'h20, 4'hF);
      wr(5'h04, 32'd0, 4'hF);
      wr(5'h00, 32'h1E, 4'hF);
      wr(5'h18, 32'd0, 4'hF);
      wr(5'h10, 32'd3, 4'hF);
      idle(3);
      chk("irq_lag", 64'(irq_n), 1);
      rd("pend_set", 5'h14, 32'd1);
      chk("irq_on", 64'(irq_n), 0);
      wr(5'h14, 32'd1, 4'h1);
      rd("w1c_now", 5'h14, 32'd0);
      rd("w1c_re", 5'h14, 32'd1);
      wr(5'h0C, 32'd1, 4'hF);
      wr(5'h14, 32'd1, 4'h1);
      rd("w1c_done", 5'h14, 32'd0);
      idle(1);
      chk("irq_off", 64'(irq_n), 1);
      rd("w1c_stay", 5'h14, 32'd0);

      wr(5'h08, 32'h1122_3344, 4'hF);
      wr(5'h08, 32'hAABB_CCDD, 4'b0101);
      rd("lanes_0101", 5'h08, 32'h11BB_33DD);
      wr(5'h08, 32'h5566_7788, 4'b1010);
      rd("lanes_1010", 5'h08, 32'h55BB_77DD);

      wr(5'h10, 32'd0, 4'hF);
      wr(5'h04, 32'hFFFF_FFFF, 4'hF);
      wr(5'h00, 32'hFFFF_FFFF, 4'hF);
      wr(5'h10, 32'd1, 4'hF);
      idle(1);
      rd("wrap_hi", 5'h04, 32'd0);
      wr(5'h00, 32'd5, 4'hF);
      rd("collide_lo", 5'h00, 32'd5);
      rd("collide_hi", 5'h04, 32'd0);

`ifdef MMIO_TIMER_PERIODIC_EN
      wr(5'h10, 32'd0, 4'hF);
      wr(5'h18, 32'd0, 4'hF);
      wr(5'h0C, 32'd0, 4'hF);
      wr(5'h08, 32'd4, 4'hF);
      wr(5'h04, 32'd0, 4'hF);
      wr(5'h00, 32'd0, 4'hF);
      wr(5'h14, 32'd1, 4'h1);
      wr(5'h10, 32'd7, 4'hF);
      for (int k = 0; k < 8; k++)
         rd($sformatf("per_%0d", k), 5'h00, 32'(k % 4));
      rd("per_pend", 5'h14, 32'd1);
      rd("per_ctrl", 5'h10, 32'd7);
`else
      wr(5'h10, 32'd7, 4'hF);
      rd("ctrl_mask", 5'h10, 32'd3);
`endif
      wr(5'h10, 32'd0, 4'hF);

      for (int n = 0; n < 400; n++) begin
         bus.sel = ($urandom_range(0, 3) != 0);
         bus.addr = 5'($urandom);
         bus.wdata = $urandom;
         bus.wenable = 4'($urandom);
         if (bus.addr[4:2] == 3'd6 || bus.addr[4:2] == 3'd1
             || bus.addr[4:2] == 3'd3)
            bus.wdata = $urandom_range(0, 3);
         @(posedge clk);
         #1;
      end
      bus.sel = 1'b0;
      bus.wenable = 4'd0;

      wr(5'h0C, 32'd0, 4'hF);
      wr(5'h08, 32'd0, 4'hF);
      wr(5'h10, 32'd3, 4'hF);
      idle(3);
      chk("irq_pre_rst", 64'(irq_n), 0);
      rst_n = 1'b0;
      #1 chk("irq_async", 64'(irq_n), 1);
      bus.sel = 1'b1;
      bus.addr = 5'h08;
      #1 chk("cmp_async", 64'(bus.rdata), 64'hFFFF_FFFF);
      bus.addr = 5'h14;
      #1 chk("sts_async", 64'(bus.rdata), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.sel = 1'b0;
      idle(2);
      rd("post_rst_sts", 5'h14, 32'd0);
      rd("post_rst_mt", 5'h00, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
